// File: rtl/csa_pkg.sv
// Shared definitions for the byte-serial carry-select adder: controller state
// encodings, byte width and the 4-bit ripple helper used by the adder slice.
package csa_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // cTop is the carry entering the top bit of the nibble, needed for overflow.
    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       cTop;
    } ripple4_t;

    function automatic ripple4_t ripple4(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       cin);
        ripple4_t r;
        logic     c;
        r = '0;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) r.cTop = c;
            r.sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r.cout = c;
        return r;
    endfunction

endpackage

// File: rtl/csa_serial_add_ctrl_if.sv
// Start/busy/done request bus between a datapath (master) and the serial adder
// controller (slave); operand width follows the NBYTES parameter.
interface csa_serial_add_ctrl_if #(parameter int NBYTES = 4);

    localparam int W = csa_pkg::BYTE_W * NBYTES;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout, ovf
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout, ovf
    );

endinterface

// File: rtl/csa8_slice.sv
// Combinational 8-bit carry-select adder: lower nibble ripples, upper nibble is
// precomputed for both carry values and selected by the lower carry-out.
module csa8_slice
    import csa_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       c7
);

    ripple4_t lo;
    ripple4_t hi0;
    ripple4_t hi1;
    ripple4_t hiSel;

    // c7 comes from the selected upper nibble so the controller can form overflow.
    always_comb begin
        lo    = ripple4(a[3:0], b[3:0], cin);
        hi0   = ripple4(a[7:4], b[7:4], 1'b0);
        hi1   = ripple4(a[7:4], b[7:4], 1'b1);
        hiSel = lo.cout ? hi1 : hi0;
        sum   = {hiSel.sum, lo.sum};
        cout  = hiSel.cout;
        c7    = hiSel.cTop;
    end

endmodule

// File: rtl/csa_serial_add_ctrl.sv
// Byte-serial adder controller: feeds one shared 8-bit carry-select slice one
// byte per clock, LSB first, chaining the carry through a register.
module csa_serial_add_ctrl
    import csa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic                 clk,
    input logic                 rst,
    csa_serial_add_ctrl_if.slave bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           state;
    state_t           stateNext;
    logic [IDX_W-1:0] byteIdx;
    logic [W-1:0]     aReg;
    logic [W-1:0]     bReg;
    logic [W-1:0]     sumReg;
    logic             carryReg;
    logic             coutReg;
    logic             ovfReg;

    logic [7:0] sliceA;
    logic [7:0] sliceB;
    logic [7:0] sliceSum;
    logic       sliceCout;
    logic       sliceC7;
    logic       accept;
    logic       lastByte;

    assign accept   = (state == ST_IDLE) && bus.start;
    assign lastByte = (byteIdx == LAST_IDX);
    assign sliceA   = aReg[BYTE_W*byteIdx +: BYTE_W];
    assign sliceB   = bReg[BYTE_W*byteIdx +: BYTE_W];

    csa8_slice u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carryReg),
        .sum  (sliceSum),
        .cout (sliceCout),
        .c7   (sliceC7)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (bus.start) stateNext = ST_ADD;
            ST_ADD:  if (lastByte)  stateNext = ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Operands are captured only on an accepted start, so A/B/Cin may move while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byteIdx  <= '0;
            aReg     <= '0;
            bReg     <= '0;
            sumReg   <= '0;
            carryReg <= 1'b0;
            coutReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else if (accept) begin
            byteIdx  <= '0;
            aReg     <= bus.A;
            bReg     <= bus.B;
            sumReg   <= '0;
            carryReg <= bus.Cin;
            coutReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else if (state == ST_ADD) begin
            sumReg[BYTE_W*byteIdx +: BYTE_W] <= sliceSum;
            carryReg <= sliceCout;
            if (lastByte) begin
                coutReg <= sliceCout;
                ovfReg  <= sliceC7 ^ sliceCout;
            end else begin
                byteIdx <= byteIdx + 1'b1;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.S    = sumReg;
    assign bus.Cout = coutReg;
    assign bus.ovf  = ovfReg;

endmodule
